viterbi_pmu_norm: RTL

Parametrised path-metric register bank for the Viterbi decoder: the next generation of the fixed 4-state, 8-bit PMU. It holds one path metric per trellis state and loads the ACS results on every valid symbol. It also renormalises the metrics so they never overflow, and reports the current best (minimum-metric) state to the traceback unit. It sits between the ACS array (feeding `pm_new_i`) and both the ACS inputs and the traceback start-state logic (reading the outputs).

---
 rtl/viterbi_pkg.sv | 20 ++
 rtl/pm_min_tree.sv | 38 +++
 rtl/viterbi_pmu_norm.sv | 127 ++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared defaults, metric type and init-pattern helper for the Viterbi path-metric logic.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package viterbi_pkg;

    localparam int PM_W_DEF       = 8;
    localparam int NUM_STATES_DEF = 4;

    typedef logic [PM_W_DEF-1:0] pm_t;

    // Metric for `state` right after init: the start state is certain (0),
    // every other state is as unlikely as the metric width allows.
    function automatic logic [31:0] init_metric(input int state, input int init_state, input int pm_w);
        if (state == init_state) begin
            return 32'd0;
        end
        return 32'((64'd1 << pm_w) - 64'd1);
    endfunction

endpackage

// File: rtl/pm_min_tree.sv
// Combinational argmin over N packed metrics, lowest index wins ties.
// Latency: 0 cycles (pure combinational, log2(N) compare levels).
// Backpressure: none; output follows input every cycle.
module pm_min_tree #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic [N*W-1:0]       pm_i,
    output logic [W-1:0]         min_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int IW = $clog2(N);

    // Heap layout: node j has children 2j+1 (left, lower indices) and 2j+2.
    logic [W-1:0]  node_val [2*N-1];
    logic [IW-1:0] node_idx [2*N-1];

    // Build the compare tree bottom-up; the left child is kept on equality.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            node_val[N-1+i] = pm_i[i*W +: W];
            node_idx[N-1+i] = IW'(i);
        end
        for (int j = N - 2; j >= 0; j--) begin
            if (node_val[2*j+2] < node_val[2*j+1]) begin
                node_val[j] = node_val[2*j+2];
                node_idx[j] = node_idx[2*j+2];
            end else begin
                node_val[j] = node_val[2*j+1];
                node_idx[j] = node_idx[2*j+1];
            end
        end
        min_o = node_val[0];
        idx_o = node_idx[0];
    end

endmodule

// File: rtl/viterbi_pmu_norm.sv
// Path-metric register bank with renormalisation and best-state tracking.
// Latency: 1 cycle from valid_i to registered metrics / valid_o.
// Backpressure: none; accepts one load per cycle, flush drops the load.
module viterbi_pmu_norm
    import viterbi_pkg::*;
#(
    parameter int NUM_STATES  = NUM_STATES_DEF,
    parameter int PM_W        = PM_W_DEF,
    parameter int INIT_STATE  = 0,
    parameter int NORM_THRESH = 128
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_i,
    input  logic                          flush_i,
    input  logic [NUM_STATES*PM_W-1:0]    pm_new_i,
    output logic [NUM_STATES*PM_W-1:0]    pm_current_o,
    output logic                          valid_o,
    output logic [$clog2(NUM_STATES)-1:0] best_state_o,
    output logic [PM_W-1:0]               best_pm_o,
    output logic                          norm_o,
    output logic [15:0]                   norm_cnt_o
);

    localparam int SW = $clog2(NUM_STATES);
    localparam int VW = NUM_STATES * PM_W;
    localparam logic [PM_W-1:0] THRESH = PM_W'(NORM_THRESH);

    function automatic logic [VW-1:0] init_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            v[i*PM_W +: PM_W] = PM_W'(init_metric(i, INIT_STATE, PM_W));
        end
        return v;
    endfunction

    localparam logic [VW-1:0]   INIT_PM   = init_vec();
    localparam logic [SW-1:0]   INIT_BEST = SW'(INIT_STATE);

    logic [VW-1:0]   pm_d, pm_q;
    logic [SW-1:0]   best_state_d, best_state_q;
    logic [PM_W-1:0] best_pm_d, best_pm_q;
    logic            valid_d, valid_q;
    logic            norm_d, norm_q;
    logic [15:0]     norm_cnt_d, norm_cnt_q;

    logic [PM_W-1:0] min_val;
    logic [SW-1:0]   min_idx;
    logic            do_norm;
    logic [VW-1:0]   pm_norm;

    pm_min_tree #(
        .N (NUM_STATES),
        .W (PM_W)
    ) u_min_tree (
        .pm_i  (pm_new_i),
        .min_o (min_val),
        .idx_o (min_idx)
    );

    // Shift every metric down by the minimum; min_val <= each input, so no underflow.
    always_comb begin
        pm_norm = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            pm_norm[i*PM_W +: PM_W] = pm_new_i[i*PM_W +: PM_W] - min_val;
        end
        do_norm = (min_val >= THRESH);
    end

    // Next-state selection: flush beats load, idle cycles hold metrics and drop pulses.
    always_comb begin
        pm_d         = pm_q;
        best_state_d = best_state_q;
        best_pm_d    = best_pm_q;
        valid_d      = 1'b0;
        norm_d       = 1'b0;
        norm_cnt_d   = norm_cnt_q;
        if (flush_i) begin
            pm_d         = INIT_PM;
            best_state_d = INIT_BEST;
            best_pm_d    = '0;
            norm_cnt_d   = '0;
        end else if (valid_i) begin
            valid_d      = 1'b1;
            best_state_d = min_idx;
            if (do_norm) begin
                pm_d      = pm_norm;
                best_pm_d = '0;
                norm_d    = 1'b1;
                if (norm_cnt_q != 16'hFFFF) begin
                    norm_cnt_d = norm_cnt_q + 16'd1;
                end
            end else begin
                pm_d      = pm_new_i;
                best_pm_d = min_val;
            end
        end
    end

    // State registers; reset restores the init metric pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q         <= INIT_PM;
            best_state_q <= INIT_BEST;
            best_pm_q    <= '0;
            valid_q      <= 1'b0;
            norm_q       <= 1'b0;
            norm_cnt_q   <= '0;
        end else begin
            pm_q         <= pm_d;
            best_state_q <= best_state_d;
            best_pm_q    <= best_pm_d;
            valid_q      <= valid_d;
            norm_q       <= norm_d;
            norm_cnt_q   <= norm_cnt_d;
        end
    end

    assign pm_current_o = pm_q;
    assign best_state_o = best_state_q;
    assign best_pm_o    = best_pm_q;
    assign valid_o      = valid_q;
    assign norm_o       = norm_q;
    assign norm_cnt_o   = norm_cnt_q;

endmodule
